// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES tables, mode/padding codes and helper functions
package des_pkg;
  localparam int DES_BLK_W     = 64;
  localparam int BYTES_PER_BLK = 8;

  typedef enum logic [2:0] {
    MODE_ECB = 3'b000,
    MODE_CBC = 3'b001
  } mode_e;

  typedef enum logic [2:0] {
    PAD_NONE     = 3'b000,
    PAD_ZEROS    = 3'b001,
    PAD_PKCS7    = 3'b010,
    PAD_ANSIX923 = 3'b011,
    PAD_ISO10126 = 3'b100,
    PAD_ONE_ZERO = 3'b101
  } pad_e;

  typedef struct packed {
    logic       err;
    logic [3:0] bytes;
  } pad_res_t;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                              16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                                60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,
                                61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  // Rounds 1, 2, 9 and 16 rotate by one; all others by two
  localparam logic [15:0] SHIFT1 = 16'b1000_0001_0000_0011;

  // Each S-box is 64 nibbles, entry 0 in the top nibble
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] k);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = k[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] cd);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = cd[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
    logic [255:0] t;
    t = SBOX[n] << {b[5], b[0], b[4:1], 2'b00};
    return t[255:252];
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, y;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
    x = x ^ k;
    for (int j = 0; j < 8; j++) s[5'(31 - 4 * j) -: 4] = sbox(3'(j), x[6'(47 - 6 * j) -: 6]);
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  // b[0] is the final byte of the block, b[7] the first
  function automatic pad_res_t pad_decode(input logic [63:0] p, input logic [2:0] pad);
    logic [7:0][7:0] b;
    logic [7:0]      n, lnz;
    logic [3:0]      tz, lnz_idx;
    logic            zrun, nval, pkcs_ok, ansi_ok;
    pad_res_t        res;
    b = p;
    n = p[7:0];
    nval = (n != 8'd0) && (n <= 8'd8);
    pkcs_ok = nval;
    ansi_ok = nval;
    tz = 4'd0;
    zrun = 1'b1;
    lnz = 8'd0;
    lnz_idx = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (zrun && b[3'(i)] == 8'd0) tz = tz + 4'd1;
      else zrun = 1'b0;
      if (8'(i) < n && b[3'(i)] != n) pkcs_ok = 1'b0;
      if (i > 0 && 8'(i) < n && b[3'(i)] != 8'd0) ansi_ok = 1'b0;
    end
    for (int i = 7; i >= 0; i--) begin
      if (b[3'(i)] != 8'd0) begin
        lnz = b[3'(i)];
        lnz_idx = 4'(7 - i);
      end
    end
    res.err = 1'b0;
    res.bytes = 4'(BYTES_PER_BLK);
    case (pad)
      PAD_ZEROS:    res.bytes = 4'(BYTES_PER_BLK) - tz;
      PAD_PKCS7:    if (pkcs_ok) res.bytes = 4'd8 - n[3:0]; else res.err = 1'b1;
      PAD_ANSIX923: if (ansi_ok) res.bytes = 4'd8 - n[3:0]; else res.err = 1'b1;
      PAD_ISO10126: if (nval) res.bytes = 4'd8 - n[3:0]; else res.err = 1'b1;
      PAD_ONE_ZERO: if (lnz == 8'h80) res.bytes = lnz_idx; else res.err = 1'b1;
      default:      res.bytes = 4'(BYTES_PER_BLK);
    endcase
    return res;
  endfunction
endpackage

// File: rtl/des_chain_fifo.sv
// rtl/des_chain_fifo.sv - synchronous FIFO carrying {last, chain} alongside the core
module des_chain_fifo #(
  parameter int DEPTH = 32,
  parameter int W     = 65
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_do_push, w_do_pop;

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  // A pop frees the slot, so push-while-full is accepted when popping
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_do_pop)  r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_do_push && w_do_pop) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/des_dec.sv
// rtl/des_dec.sv - 16-stage pipelined DES decryption core, one round per stage
module des_dec
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] i_key,
  input  logic [63:0] i_din,
  input  logic        i_din_en,
  output logic [63:0] o_dout,
  output logic        o_cipher_rdy
);
  logic [47:0] w_sk  [16];
  logic [31:0] w_lin [16];
  logic [31:0] w_rin [16];
  logic [63:0] w_ip;
  logic [31:0] r_l   [16];
  logic [31:0] r_r   [16];
  logic [15:0] r_v;

  always_comb begin
    logic [55:0] cd;
    logic [27:0] c, d;
    cd = perm_pc1(i_key);
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      if (SHIFT1[4'(r)]) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end else begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end
      w_sk[4'(r)] = perm_pc2({c, d});
    end
  end

  assign w_ip = perm_ip(i_din);

  always_comb begin
    w_lin[0] = w_ip[63:32];
    w_rin[0] = w_ip[31:0];
    for (int s = 1; s < 16; s++) begin
      w_lin[4'(s)] = r_l[4'(s - 1)];
      w_rin[4'(s)] = r_r[4'(s - 1)];
    end
  end

  // Decryption walks the key schedule backwards: stage s uses K(16-s)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v <= '0;
      for (int s = 0; s < 16; s++) begin
        r_l[4'(s)] <= '0;
        r_r[4'(s)] <= '0;
      end
    end else begin
      r_v <= {r_v[14:0], i_din_en};
      for (int s = 0; s < 16; s++) begin
        r_l[4'(s)] <= w_rin[4'(s)];
        r_r[4'(s)] <= w_lin[4'(s)] ^ des_f(w_rin[4'(s)], w_sk[4'(15 - s)]);
      end
    end
  end

  assign o_dout       = perm_fp({r_r[15], r_l[15]});
  assign o_cipher_rdy = r_v[15];
endmodule

// File: rtl/des_dec_block.sv
// rtl/des_dec_block.sv - DES decrypt wrapper with ECB/CBC chaining and padding strip
module des_dec_block
  import des_pkg::*;
#(
  parameter int CHAIN_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DES_BLK_W-1:0] i_cipher,
  input  logic                 i_cipher_en,
  input  logic                 i_cipher_last,
  input  logic [DES_BLK_W-1:0] i_key,
  input  logic [2:0]           i_mode,
  input  logic [DES_BLK_W-1:0] i_iv,
  input  logic                 i_iv_update,
  input  logic [2:0]           i_padding,
  output logic [DES_BLK_W-1:0] o_plain,
  output logic                 o_plain_rdy,
  output logic                 o_plain_last,
  output logic [3:0]           o_plain_bytes,
  output logic                 o_pad_err,
  output logic                 o_sync_err
);
  logic [DES_BLK_W-1:0] r_chain;
  logic [DES_BLK_W-1:0] w_chain_val, w_core_out, w_pt;
  logic [DES_BLK_W:0]   w_head;
  logic                 w_core_rdy, w_full, w_empty, w_mode_ok;
  pad_res_t             w_pad;

  assign w_chain_val = i_iv_update ? i_iv : r_chain;

  des_dec u_core (
    .clk          (clk),
    .rstn         (rstn),
    .i_key        (i_key),
    .i_din        (i_cipher),
    .i_din_en     (i_cipher_en),
    .o_dout       (w_core_out),
    .o_cipher_rdy (w_core_rdy)
  );

  des_chain_fifo #(.DEPTH(CHAIN_DEPTH), .W(DES_BLK_W + 1)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (i_cipher_en),
    .i_din   ({i_cipher_last, w_chain_val}),
    .i_pop   (w_core_rdy),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_mode_ok = (i_mode == MODE_ECB) || (i_mode == MODE_CBC);

  always_comb begin
    w_pt  = (i_mode == MODE_CBC) ? (w_core_out ^ w_head[DES_BLK_W-1:0]) : w_core_out;
    w_pad = pad_decode(w_pt, i_padding);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_chain       <= '0;
      o_plain       <= '0;
      o_plain_rdy   <= 1'b0;
      o_plain_last  <= 1'b0;
      o_plain_bytes <= '0;
      o_pad_err     <= 1'b0;
      o_sync_err    <= 1'b0;
    end else begin
      if (i_cipher_en)      r_chain <= i_cipher;
      else if (i_iv_update) r_chain <= i_iv;
      if ((i_cipher_en && w_full && !w_core_rdy) || (w_core_rdy && w_empty)) o_sync_err <= 1'b1;
      o_plain_rdy  <= 1'b0;
      o_plain_last <= 1'b0;
      o_pad_err    <= 1'b0;
      if (w_core_rdy && w_mode_ok) begin
        o_plain       <= w_pt;
        o_plain_rdy   <= 1'b1;
        o_plain_last  <= w_head[DES_BLK_W];
        o_plain_bytes <= w_head[DES_BLK_W] ? w_pad.bytes : 4'(BYTES_PER_BLK);
        o_pad_err     <= w_head[DES_BLK_W] && w_pad.err;
      end else if (w_core_rdy) begin
        o_plain       <= '0;
        o_plain_bytes <= '0;
      end
    end
  end
endmodule
